// File: rtl/mem_io_bridge_pkg.sv
// Shared constants and types for the cpu memory/IO bridge: IO port map,
// read-select encoding and the byte width used by every datapath.
package mem_io_bridge_pkg;

    localparam int BYTE_W = 8;

    localparam logic [17:0] IO_BASE      = 18'h30000;
    localparam logic [17:0] IO_PORT_DATA = 18'h30000;
    localparam logic [17:0] IO_PORT_CNT  = 18'h30004;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_RX,
        SEL_CNT,
        SEL_ZERO
    } rd_sel_e;

endpackage

// File: rtl/mem_io_bridge_if.sv
// cpu memory port as seen by the bridge: master is the cpu side,
// slave is the bridge side.
interface mem_io_bridge_if;
    import mem_io_bridge_pkg::*;

    logic              rdy_in;
    logic [31:0]       cpu_a;
    logic [BYTE_W-1:0] cpu_dout;
    logic              cpu_wr;
    logic [BYTE_W-1:0] cpu_din;
    logic              io_buffer_full;

    modport master (
        output rdy_in, cpu_a, cpu_dout, cpu_wr,
        input  cpu_din, io_buffer_full
    );

    modport slave (
        input  rdy_in, cpu_a, cpu_dout, cpu_wr,
        output cpu_din, io_buffer_full
    );

endinterface

// File: rtl/mem_io_bridge_byte_fifo.sv
// Circular byte FIFO (DEPTH a power of 2) with a count of width log2(DEPTH)+1.
// A push while full is dropped unless a pop happens in the same cycle.
module mem_io_bridge_byte_fifo
    import mem_io_bridge_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              empty,
    output logic              drop,
    output logic [AW:0]       count_next
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // At full the popped slot is the one being written, so both can proceed.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes cpu byte accesses to RAM, UART tx/rx and the cycle counter.
// Optional macro IO_BRIDGE_RX_FIFO_EN replaces the rx holding register with a FIFO.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int TX_DEPTH  = 16,
    parameter int TX_MARGIN = 2,
    parameter int RX_DEPTH  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_bridge_if.slave    cpu,
    output logic [16:0]       ram_a,
    output logic [BYTE_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [BYTE_W-1:0] ram_dout,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              prog_stop,
    output logic              tx_overflow
);

    localparam int TX_AW = $clog2(TX_DEPTH);

    logic [17:0]       addr;
    logic              is_io, rd_acc, wr_acc, data_port, cnt_port, cnt_wr;
    logic              tx_push, tx_empty, tx_drop;
    logic [BYTE_W-1:0] tx_push_data;
    logic [TX_AW:0]    tx_count_next;
    logic              rx_present, rx_pop;
    logic [BYTE_W-1:0] rx_byte;
    rd_sel_e           rd_sel, sel_q;
    logic              sel_live_q;
    logic [1:0]        idx_q;
    logic [BYTE_W-1:0] rx_q;
    logic [31:0]       cnt, snap;

    assign addr      = cpu.cpu_a[17:0];
    assign is_io     = (addr[17:16] == IO_BASE[17:16]);
    assign rd_acc    = cpu.rdy_in & ~cpu.cpu_wr;
    assign wr_acc    = cpu.rdy_in & cpu.cpu_wr;
    assign data_port = (addr == IO_PORT_DATA);
    assign cnt_port  = (addr[17:2] == IO_PORT_CNT[17:2]);
    assign cnt_wr    = wr_acc & (addr == IO_PORT_CNT);

    assign ram_a   = cpu.cpu_a[16:0];
    assign ram_din = cpu.cpu_dout;
    assign ram_we  = wr_acc & ~is_io;

    // A zero byte on the data port is swallowed; the stop port sends the 0x00 marker.
    assign tx_push      = (wr_acc & data_port & (cpu.cpu_dout != '0)) | cnt_wr;
    assign tx_push_data = data_port ? cpu.cpu_dout : '0;

    // tx handshake: a byte moves on every cycle where tx_valid and tx_ready are
    // both high; tx_data holds steady while tx_valid is high and tx_ready is low.
    mem_io_bridge_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (tx_push),
        .push_data  (tx_push_data),
        .pop        (tx_valid & tx_ready),
        .head       (tx_data),
        .empty      (tx_empty),
        .drop       (tx_drop),
        .count_next (tx_count_next)
    );
    assign tx_valid = ~tx_empty;

    assign rx_pop = rd_acc & data_port & rx_present;

`ifdef IO_BRIDGE_RX_FIFO_EN
    logic                         rx_empty;
    logic                         rx_drop;
    logic [$clog2(RX_DEPTH):0]    rx_count_next;

    mem_io_bridge_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .push       (rx_valid),
        .push_data  (rx_data),
        .pop        (rx_pop),
        .head       (rx_byte),
        .empty      (rx_empty),
        .drop       (rx_drop),
        .count_next (rx_count_next)
    );
    assign rx_present = ~rx_empty;
`else
    logic [BYTE_W-1:0] rx_hold;
    logic              rx_hold_v;

    assign rx_present = rx_hold_v;
    assign rx_byte    = rx_hold;

    // A new byte wins over a same-cycle read; the read still sees the old byte.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_hold   <= '0;
            rx_hold_v <= 1'b0;
        end else if (rx_valid) begin
            rx_hold   <= rx_data;
            rx_hold_v <= 1'b1;
        end else if (rx_pop) begin
            rx_hold_v <= 1'b0;
        end
    end
`endif

    always_comb begin
        rd_sel = SEL_RAM;
        if (is_io) begin
            if (data_port)     rd_sel = rx_present ? SEL_RX : SEL_ZERO;
            else if (cnt_port) rd_sel = SEL_CNT;
            else               rd_sel = SEL_ZERO;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_q              <= SEL_RAM;
            sel_live_q         <= 1'b0;
            idx_q              <= '0;
            rx_q               <= '0;
            cnt                <= '0;
            snap               <= '0;
            prog_stop          <= 1'b0;
            tx_overflow        <= 1'b0;
            cpu.io_buffer_full <= 1'b0;
        end else begin
            if (cpu.rdy_in) cnt <= cnt + 32'd1;
            if (rd_acc) begin
                sel_q      <= rd_sel;
                sel_live_q <= 1'b1;
                idx_q      <= addr[1:0];
                rx_q       <= rx_byte;
            end
            if (rd_acc && cnt_port && addr[1:0] == 2'd0) snap <= cnt;
            prog_stop <= cnt_wr;
            if (tx_drop) tx_overflow <= 1'b1;
            cpu.io_buffer_full <= (TX_DEPTH - int'(tx_count_next)) <= TX_MARGIN;
        end
    end

    // sel_live_q keeps cpu_din at 0 after reset until a read has been issued,
    // since the cleared select would otherwise expose ram_dout.
    always_comb begin
        cpu.cpu_din = '0;
        if (sel_live_q) begin
            case (sel_q)
                SEL_RAM: cpu.cpu_din = ram_dout;
                SEL_RX:  cpu.cpu_din = rx_q;
                SEL_CNT: cpu.cpu_din = snap[{idx_q, 3'b000} +: BYTE_W];
                default: cpu.cpu_din = '0;
            endcase
        end
    end

endmodule
